// File: rtl/hangman_pkg.sv
// Shared definitions for the hangman game controllers: state encodings,
// default configuration constants and saturating arithmetic helpers.
package hangman_pkg;

  typedef enum logic [3:0] {
    S_LOAD_C     = 4'd0,
    S_LOAD_WAIT  = 4'd1,
    S_LOAD_GRAPH = 4'd2,
    S_WAIT_GRAPH = 4'd3,
    S_GUESS      = 4'd4,
    S_EVAL       = 4'd5,
    S_FILL       = 4'd6,
    S_DRAW       = 4'd7,
    S_WIN        = 4'd8,
    S_LOSE       = 4'd9
  } state_e;

  localparam int unsigned DEF_NUM_PLAYERS  = 2;
  localparam int unsigned DEF_MAX_WORD_LEN = 16;
  localparam int unsigned DEF_MAX_MISSES   = 10;
  localparam int unsigned DEF_TURN_CYCLES  = 50000000;
  localparam int unsigned DEF_SCORE_W      = 4;

  function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                          input int unsigned max);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max}) ? max : sum[31:0];
  endfunction

endpackage

// File: rtl/hangman_ctrl_mp_turn_timer.sv
// Per-turn cycle counter: clear has priority over enable; expire flags the
// last allowed cycle while counting is enabled.
module turn_timer #(
  parameter int unsigned CYCLES = 50000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)     count_d = '0;
    else if (en_i) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign expire_o = en_i && (count_q == LAST);

endmodule

// File: rtl/hangman_ctrl_mp.sv
// Multi-player hangman game controller: sequences word entry, guessing,
// reveal fill and gallows drawing, and owns the game counters and scores.
module hangman_ctrl_mp
  import hangman_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS  = DEF_NUM_PLAYERS,
  parameter int unsigned MAX_WORD_LEN = DEF_MAX_WORD_LEN,
  parameter int unsigned MAX_MISSES   = DEF_MAX_MISSES,
  parameter int unsigned TURN_CYCLES  = DEF_TURN_CYCLES,
  parameter int unsigned SCORE_W      = DEF_SCORE_W
) (
  input  logic clk,
  input  logic resetn,
  input  logic load,
  input  logic endinput,
  input  logic start,
  input  logic try,
  input  logic wipe,
  input  logic graph_loaded,
  input  logic match_valid,
  input  logic [$clog2(MAX_WORD_LEN+1)-1:0] match_cnt,
  input  logic fill_done,
  input  logic draw_done,
  output logic wren,
  output logic ld_g,
  output logic compare,
  output logic fill,
  output logic draw,
  output logic plot,
  output logic over,
  output logic timeout,
  output logic [$clog2(MAX_MISSES+1)-1:0] part,
  output logic [((NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1)-1:0] cur_player,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic [$clog2(MAX_WORD_LEN+1)-1:0] word_len,
  output logic [$clog2(MAX_WORD_LEN+1)-1:0] remain,
  output logic [3:0] state
);

  localparam int unsigned LW   = $clog2(MAX_WORD_LEN + 1);
  localparam int unsigned PTW  = $clog2(MAX_MISSES + 1);
  localparam int unsigned PW   = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int unsigned SMAX = (2 ** SCORE_W) - 1;

  state_e              state_q, state_d;
  logic [LW-1:0]       word_len_q, word_len_d;
  logic [LW-1:0]       remain_q, remain_d;
  logic [PTW-1:0]      part_q, part_d;
  logic [PW-1:0]       player_q, player_d;
  logic [SCORE_W-1:0]  score_q [NUM_PLAYERS];
  logic [SCORE_W-1:0]  score_d [NUM_PLAYERS];
  logic                cmp_first_q, cmp_first_d;
  logic                tmr_clr, tmr_en, tmr_expire;
  logic [5:0]          strobe;

  assign tmr_en = (state_q == S_GUESS);

  turn_timer #(.CYCLES(TURN_CYCLES)) u_turn_timer (
    .clk_i    (clk),
    .rst_ni   (resetn),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .expire_o (tmr_expire)
  );

  always_comb begin
    state_d     = state_q;
    word_len_d  = word_len_q;
    remain_d    = remain_q;
    part_d      = part_q;
    player_d    = player_q;
    score_d     = score_q;
    cmp_first_d = 1'b0;
    tmr_clr     = 1'b0;
    unique case (state_q)
      S_LOAD_C: begin
        if (load) begin
          if (word_len_q < LW'(MAX_WORD_LEN)) begin
            word_len_d = word_len_q + 1'b1;
            state_d    = S_LOAD_WAIT;
          end
        end else if (endinput && (word_len_q != '0)) begin
          state_d = S_LOAD_GRAPH;
        end
      end
      S_LOAD_WAIT: state_d = S_LOAD_C;
      S_LOAD_GRAPH: begin
        if (start) begin
          state_d  = S_WAIT_GRAPH;
          remain_d = word_len_q;
        end
      end
      S_WAIT_GRAPH: begin
        if (graph_loaded) begin
          state_d = S_GUESS;
          tmr_clr = 1'b1;
        end
      end
      S_GUESS: begin
        if (try) begin
          state_d     = S_EVAL;
          cmp_first_d = 1'b1;
        end else if (tmr_expire) begin
          state_d = S_DRAW;
          part_d  = PTW'(sat_add(32'(part_q), 1, MAX_MISSES));
        end
      end
      S_EVAL: begin
        if (match_valid) begin
          if (match_cnt != '0) begin
            remain_d = (match_cnt >= remain_q) ? '0 : remain_q - match_cnt;
            score_d[player_q] = SCORE_W'(sat_add(32'(score_q[player_q]),
                                                 32'(match_cnt), SMAX));
            state_d  = S_FILL;
          end else begin
            state_d = S_DRAW;
            part_d  = PTW'(sat_add(32'(part_q), 1, MAX_MISSES));
          end
        end
      end
      S_FILL: begin
        if (fill_done) begin
          if (remain_q == '0) begin
            state_d = S_WIN;
          end else begin
            state_d = S_GUESS;
            tmr_clr = 1'b1;
          end
        end
      end
      S_DRAW: begin
        // Rotation also happens on the final miss, so the losing draw hands
        // the turn on like any other.
        if (draw_done) begin
          player_d = (player_q == PW'(NUM_PLAYERS - 1)) ? '0 : player_q + 1'b1;
          if (part_q == PTW'(MAX_MISSES)) begin
            state_d = S_LOSE;
          end else begin
            state_d = S_GUESS;
            tmr_clr = 1'b1;
          end
        end
      end
      S_WIN, S_LOSE: begin
        if (wipe) begin
          state_d    = S_LOAD_C;
          word_len_d = '0;
          remain_d   = '0;
          part_d     = '0;
          player_d   = '0;
          tmr_clr    = 1'b1;
        end
      end
      default: state_d = S_LOAD_C;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_LOAD_C;
      word_len_q  <= '0;
      remain_q    <= '0;
      part_q      <= '0;
      player_q    <= '0;
      cmp_first_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) score_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      word_len_q  <= word_len_d;
      remain_q    <= remain_d;
      part_q      <= part_d;
      player_q    <= player_d;
      cmp_first_q <= cmp_first_d;
      score_q     <= score_d;
    end
  end

  // Strobe order {wren, ld_g, compare, fill, draw, plot}; forced low in reset.
  always_comb begin
    strobe = '0;
    unique case (state_q)
      S_LOAD_C:      strobe = 6'b100001;
      S_LOAD_GRAPH:  strobe = 6'b010001;
      S_EVAL:        strobe = cmp_first_q ? 6'b101000 : 6'b000000;
      S_FILL:        strobe = 6'b000101;
      S_DRAW:        strobe = 6'b000011;
      S_WIN, S_LOSE: strobe = 6'b000001;
      default:       strobe = '0;
    endcase
    strobe = strobe & {6{resetn}};
  end

  assign {wren, ld_g, compare, fill, draw, plot} = strobe;
  assign over    = resetn && wipe && ((state_q == S_WIN) || (state_q == S_LOSE));
  assign timeout = resetn && tmr_en && tmr_expire;

  assign part       = part_q;
  assign cur_player = player_q;
  assign word_len   = word_len_q;
  assign remain     = remain_q;
  assign state      = state_q;

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_score
    assign scores[g*SCORE_W +: SCORE_W] = score_q[g];
  end

endmodule

// File: tb/tb_hangman_ctrl_mp.sv
// Directed and randomized checks of hangman_ctrl_mp against a transaction-level
// model of the game rules (word length, remaining letters, misses, turns, scores).
module tb_hangman_ctrl_mp;
  import hangman_pkg::*;

  localparam int unsigned NP = 2, MWL = 16, MM = 2, TC = 8, SW = 2, SMAX = 3;

  logic clk = 1'b0, resetn = 1'b0;
  logic load = 0, endinput = 0, start = 0, try = 0, wipe = 0;
  logic graph_loaded = 0, match_valid = 0, fill_done = 0, draw_done = 0;
  logic [4:0] match_cnt = '0;
  logic wren, ld_g, compare, fill, draw, plot, over, timeout;
  logic [1:0] part;
  logic [0:0] cur_player;
  logic [3:0] scores;
  logic [4:0] word_len, remain;
  logic [3:0] state;

  int errors = 0, checks = 0;
  state_e      m_state;
  int unsigned m_wl, m_rem, m_part, m_pl;
  int unsigned m_sc [NP];
  bit          m_first, m_to;

  hangman_ctrl_mp #(
    .NUM_PLAYERS(NP), .MAX_WORD_LEN(MWL), .MAX_MISSES(MM),
    .TURN_CYCLES(TC), .SCORE_W(SW)
  ) dut (
    .clk(clk), .resetn(resetn), .load(load), .endinput(endinput), .start(start),
    .try(try), .wipe(wipe), .graph_loaded(graph_loaded), .match_valid(match_valid),
    .match_cnt(match_cnt), .fill_done(fill_done), .draw_done(draw_done),
    .wren(wren), .ld_g(ld_g), .compare(compare), .fill(fill), .draw(draw),
    .plot(plot), .over(over), .timeout(timeout), .part(part),
    .cur_player(cur_player), .scores(scores), .word_len(word_len),
    .remain(remain), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] exp_strobes(input state_e s, input bit first);
    case (s)
      S_LOAD_C:      return 6'b100001;
      S_LOAD_GRAPH:  return 6'b010001;
      S_EVAL:        return first ? 6'b101000 : 6'b000000;
      S_FILL:        return 6'b000101;
      S_DRAW:        return 6'b000011;
      S_WIN, S_LOSE: return 6'b000001;
      default:       return 6'b000000;
    endcase
  endfunction

  task automatic chk_all(input string tag);
    chk({tag, "/state"},    32'(state),      32'(m_state));
    chk({tag, "/word_len"}, 32'(word_len),   m_wl);
    chk({tag, "/remain"},   32'(remain),     m_rem);
    chk({tag, "/part"},     32'(part),       m_part);
    chk({tag, "/player"},   32'(cur_player), m_pl);
    chk({tag, "/scores"},   32'(scores),     m_sc[0] + (m_sc[1] << SW));
    chk({tag, "/strobes"},  32'({wren, ld_g, compare, fill, draw, plot}),
        32'(exp_strobes(m_state, m_first)));
    chk({tag, "/timeout"},  32'(timeout),    32'(m_to));
    chk({tag, "/over"},     32'(over),       0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    m_first = 1'b0;
    m_to    = 1'b0;
  endtask

  task automatic model_restart();
    m_state = S_LOAD_C; m_wl = 0; m_rem = 0; m_part = 0; m_pl = 0;
  endtask

  task automatic load_word(input int unsigned n, input bit with_end);
    for (int i = 0; i < int'(n); i++) begin
      load = 1'b1;
      endinput = with_end && ($urandom_range(0, 1) == 1);
      tick();
      load = 1'b0; endinput = 1'b0;
      if (m_wl < MWL) begin
        m_wl++;
        m_state = S_LOAD_WAIT;
      end
      chk_all("load");
      if (m_state == S_LOAD_WAIT) begin
        tick();
        m_state = S_LOAD_C;
        chk_all("load_ret");
      end
    end
  endtask

  task automatic start_game();
    endinput = 1'b1; tick(); endinput = 1'b0;
    m_state = S_LOAD_GRAPH;
    chk_all("endinput");
    for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
      graph_loaded = 1'b1; tick(); graph_loaded = 1'b0;
      chk_all("graph_idle");
    end
    start = 1'b1; tick(); start = 1'b0;
    m_rem = m_wl; m_state = S_WAIT_GRAPH;
    chk_all("start");
    for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
      try = 1'b1; tick(); try = 1'b0;
      chk_all("wait_graph_idle");
    end
    graph_loaded = 1'b1; tick(); graph_loaded = 1'b0;
    m_state = S_GUESS;
    chk_all("graph_loaded");
  endtask

  task automatic finish_fill();
    for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
      draw_done = 1'b1; tick(); draw_done = 1'b0;
      chk_all("fill_idle");
    end
    fill_done = 1'b1; tick(); fill_done = 1'b0;
    m_state = (m_rem == 0) ? S_WIN : S_GUESS;
    chk_all("fill_done");
  endtask

  task automatic finish_draw();
    for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
      fill_done = 1'b1; tick(); fill_done = 1'b0;
      chk_all("draw_idle");
    end
    draw_done = 1'b1; tick(); draw_done = 1'b0;
    m_pl = (m_pl + 1) % NP;
    m_state = (m_part == MM) ? S_LOSE : S_GUESS;
    chk_all("draw_done");
  endtask

  task automatic do_eval(input int unsigned m);
    for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
      fill_done = 1'($urandom_range(0, 1));
      draw_done = 1'($urandom_range(0, 1));
      tick();
      fill_done = 1'b0; draw_done = 1'b0;
      chk_all("eval_idle");
    end
    match_valid = 1'b1; match_cnt = 5'(m); tick(); match_valid = 1'b0; match_cnt = '0;
    if (m == 0) begin
      m_part++;
      m_state = S_DRAW;
    end else begin
      m_rem = (m >= m_rem) ? 0 : m_rem - m;
      m_sc[m_pl] = (m_sc[m_pl] + m > SMAX) ? SMAX : m_sc[m_pl] + m;
      m_state = S_FILL;
    end
    chk_all("match");
    if (m == 0) finish_draw();
    else        finish_fill();
  endtask

  task automatic guess(input int unsigned m);
    for (int i = 0; i < int'($urandom_range(0, 5)); i++) begin
      match_valid = 1'($urandom_range(0, 1));
      match_cnt   = 5'($urandom_range(1, 16));
      tick();
      match_valid = 1'b0; match_cnt = '0;
      chk_all("guess_idle");
    end
    try = 1'b1; tick(); try = 1'b0;
    m_state = S_EVAL; m_first = 1'b1;
    chk_all("try");
    do_eval(m);
  endtask

  task automatic timeout_miss(input bit collide, input int unsigned m);
    for (int i = 1; i <= int'(TC) - 1; i++) begin
      tick();
      if (i == int'(TC) - 1) m_to = 1'b1;
      chk_all("turn_timer");
    end
    if (collide) begin
      try = 1'b1; tick(); try = 1'b0;
      m_state = S_EVAL; m_first = 1'b1;
      chk_all("try_at_expiry");
      do_eval(m);
    end else begin
      tick();
      m_part++;
      m_state = S_DRAW;
      chk_all("timeout_draw");
      finish_draw();
    end
  endtask

  task automatic end_game();
    wipe = 1'b1; #1;
    chk("over_on_wipe", 32'(over), 1);
    tick(); wipe = 1'b0;
    model_restart();
    chk_all("restart");
  endtask

  initial begin
    model_restart();
    m_sc[0] = 0; m_sc[1] = 0; m_first = 0; m_to = 0;

    // Reset state: strobes held low while resetn is low.
    tick(); tick();
    chk("rst/state",   32'(state), 32'(S_LOAD_C));
    chk("rst/strobes", 32'({wren, ld_g, compare, fill, draw, plot}), 0);
    chk("rst/counters", 32'({word_len, remain, part, cur_player, scores}), 0);
    resetn = 1'b1;
    tick();
    chk_all("post_reset");

    // endinput with an empty word and wipe outside WIN/LOSE are ignored.
    endinput = 1'b1; tick(); endinput = 1'b0;
    chk_all("empty_endinput");
    wipe = 1'b1; #1;
    chk("wipe_in_load", 32'(over), 0);
    tick(); wipe = 1'b0;
    chk_all("wipe_ignored");

    // Three-letter word won by player 0 in two guesses.
    load_word(3, 1'b0);
    start_game();
    guess(2);
    guess(1);
    chk("win/score0", 32'(scores[1:0]), 3);
    end_game();

    // 17 loads saturate at 16; a timeout then a miss lose the game.
    load_word(17, 1'b0);
    chk("wl_sat", 32'(word_len), 16);
    start_game();
    timeout_miss(1'b0, 0);
    chk("timeout/player", 32'(cur_player), 1);
    guess(0);
    chk("lose/state", 32'(state), 32'(S_LOSE));
    end_game();

    // Try on the expiry cycle wins; oversized match saturates remain and score.
    load_word(2, 1'b0);
    start_game();
    guess(0);
    timeout_miss(1'b1, 5);
    chk("sat/score1", 32'(scores[3:2]), 3);
    chk("sat/state", 32'(state), 32'(S_WIN));
    end_game();

    // Asynchronous reset in the middle of a draw.
    load_word(2, 1'b0);
    start_game();
    try = 1'b1; tick(); try = 1'b0;
    m_state = S_EVAL; m_first = 1'b1;
    chk_all("rst_try");
    match_valid = 1'b1; tick(); match_valid = 1'b0;
    m_part++; m_state = S_DRAW;
    chk_all("rst_draw");
    #3 resetn = 1'b0;
    #1;
    chk("async/state",   32'(state), 32'(S_LOAD_C));
    chk("async/outputs", 32'({wren, ld_g, compare, fill, draw, plot, over, timeout}), 0);
    chk("async/counters", 32'({word_len, remain, part, cur_player, scores}), 0);
    #1 resetn = 1'b1;
    model_restart();
    m_sc[0] = 0; m_sc[1] = 0;
    tick();
    chk_all("after_async");

    // Randomized games against the rule model.
    for (int g = 0; g < 25; g++) begin
      load_word($urandom_range(1, MWL), 1'b1);
      start_game();
      while (m_state == S_GUESS) begin
        case ($urandom_range(0, 4))
          0:       timeout_miss(1'b0, 0);
          1:       guess(0);
          2:       timeout_miss(1'b1, $urandom_range(0, 6));
          default: guess($urandom_range(1, 6));
        endcase
      end
      end_game();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hangman_ctrl_mp.md
Name: hangman_ctrl_mp

Overview:
- Parametrised multi-player successor to the game control FSM. Sequences word entry, graphic load, guessing, reveal fill and gallows drawing, with win, lose and timeout.
- Owns the counters the single-generation FSM left to the datapath: word length, remaining letters, misses, per-turn timeout, current player and per-player saturating scores.
- Sits between the keyboard decoder (single-cycle key pulses) and the datapath/VGA writer.

Parameters:
- NUM_PLAYERS, 2, number of players in rotation (1..8).
- MAX_WORD_LEN, 16, maximum letters in a secret word.
- MAX_MISSES, 10, misses that complete the drawing and end the game.
- TURN_CYCLES, 50000000, clocks allowed per guess before a turn timeout.
- SCORE_W, 4, width of each player score.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- load, endinput, start, try, wipe  in  1 each  keyboard pulses, one cycle wide
- graph_loaded  in  1  datapath: background graphic written
- match_valid  in  1  datapath: compare result ready (one-cycle pulse)
- match_cnt  in  $clog2(MAX_WORD_LEN+1)  positions newly revealed; 0 means miss
- fill_done, draw_done  in  1  datapath: fill or draw finished (one-cycle pulse)
- wren, ld_g, compare, fill, draw, plot  out  1 each  datapath/VGA strobes
- over  out  1  game-over pulse to datapath
- timeout  out  1  pulses one cycle when a turn times out
- part  out  $clog2(MAX_MISSES+1)  misses so far, which selects the drawing part
- cur_player  out  $clog2(NUM_PLAYERS)  player whose turn it is
- scores  out  NUM_PLAYERS*SCORE_W  flat score vector, player 0 in the LSBs
- word_len, remain  out  $clog2(MAX_WORD_LEN+1) each
- state  out  4  current state, for debug and HEX display

Behaviour:
- Reset is asynchronous on the negedge of resetn. It sets state=S_LOAD_C and clears all counters, part, cur_player, scores, word_len and remain. All strobes are 0 during reset.
- Outputs are Moore, decoded from the registered state, except `over` (see S_WIN/S_LOSE).
- The next-state decode is fully specified. Any unused encoding goes to S_LOAD_C.
- States and transitions:
  - S_LOAD_C: wren=plot=1.
    - load pulse with word_len<MAX_WORD_LEN: word_len+1, then go to S_LOAD_WAIT.
    - load pulse with word_len==MAX_WORD_LEN: ignored, stay.
    - endinput with word_len!=0: go to S_LOAD_GRAPH.
    - endinput with word_len==0: ignored.
    - load and endinput in the same cycle: load wins.
  - S_LOAD_WAIT: return to S_LOAD_C the next cycle. This debounces a held key.
  - S_LOAD_GRAPH: ld_g=plot=1. On start, go to S_WAIT_GRAPH and load remain=word_len.
  - S_WAIT_GRAPH: on graph_loaded, go to S_GUESS and clear the turn timer.
  - S_GUESS: the turn timer increments every cycle.
    - try pulse: go to S_EVAL, with compare=wren=1 for exactly that one cycle.
    - timer reaching TURN_CYCLES-1 with no try: go to S_DRAW as a miss and pulse timeout.
    - try and timer expiry in the same cycle: try wins.
  - S_EVAL: the timer is frozen. Wait for match_valid.
    - match_cnt!=0: remain -= match_cnt, saturating at 0. The current player's score += match_cnt, saturating at 2^SCORE_W-1. Go to S_FILL.
    - match_cnt==0: go to S_DRAW.
  - S_FILL: fill=plot=1 until fill_done.
    - If remain==0: go to S_WIN.
    - Otherwise: go to S_GUESS and clear the timer. The player keeps the turn.
  - S_DRAW: draw=plot=1. part increments on entry (once).
    - On draw_done with part==MAX_MISSES: go to S_LOSE.
    - On draw_done otherwise: go to S_GUESS, clear the timer, and cur_player advances modulo NUM_PLAYERS (wraps from NUM_PLAYERS-1 to 0).
  - S_WIN / S_LOSE: plot=1, counters frozen. wipe asserts over combinationally for that cycle. The next state is S_LOAD_C.
- Restarting from S_WIN/S_LOSE clears word_len, remain, part, cur_player and the timer. Scores persist across games and are cleared only by reset.
- wipe in any state other than S_WIN/S_LOSE is ignored.
- Key pulses arriving in states that do not consume them are dropped. They are never queued.
- match_valid, fill_done and draw_done outside their owning state are ignored.
- Reset asserted mid-game aborts immediately. No drawing handshake is completed.

Decomposition:
- Shared package hangman_pkg holds:
  - the state encodings, S_LOAD_C..S_LOSE in 4 bits;
  - the default parameter constants;
  - a function sat_add(a, b, max).
- One sub-module, turn_timer: a parametrised counter with clear, enable and expire outputs, shared with future timed modes.

Test Plan:
- Word load: 3 load pulses then endinput -> word_len=3 and state S_LOAD_GRAPH. 17 loads with MAX_WORD_LEN=16 -> word_len holds at 16.
- Win: word_len=3, start, graph_loaded, try, match_cnt=2, fill_done, try, match_cnt=1, fill_done -> remain=0, S_WIN, score[0]=3, cur_player=0.
- Lose and rotation: NUM_PLAYERS=2, MAX_MISSES=2. Two misses, each followed by draw_done -> cur_player goes 1 then 0, part=2, S_LOSE.
- Timeout: TURN_CYCLES=8, no try -> timeout pulses on cycle 8 of S_GUESS, then S_DRAW, part=1, cur_player advances.
- Saturation: SCORE_W=2 with accumulated match_cnt=5 -> score=3. match_cnt greater than remain -> remain=0, S_WIN.
- Async reset asserted in S_DRAW mid-cycle -> all outputs 0 and state S_LOAD_C before the next clk edge. wipe in S_WIN -> over=1 for one cycle, then S_LOAD_C.
